// File: rtl/noun_mem_responder_pkg.sv
// rtl/noun_mem_responder_pkg.sv - shared types and codes for the noun-memory responder
//
// Contents:
//   mem_func_e      request function codes carried on mem_func
//   state_e         responder FSM states
//   ERR_*           sticky fault codes reported on error
//   classify_fault  maps a latched request onto its fault code (ERR_NONE if legal)
package noun_mem_responder_pkg;

    typedef enum logic [1:0] {
        FUNC_NOP          = 2'd0,
        FUNC_GET_CONTENTS = 2'd1,
        FUNC_SET_CONTENTS = 2'd2,
        FUNC_GET_FREE     = 2'd3
    } mem_func_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_BAD_FUNC   = 8'h01;
    localparam logic [7:0] ERR_NIL_ADDR   = 8'h02;
    localparam logic [7:0] ERR_OUT_OF_MEM = 8'h03;

    // Address comparisons are done by the caller so this stays width-agnostic.
    function automatic logic [7:0] classify_fault(
        input mem_func_e f,
        input logic      addr1_nil,
        input logic      addr2_nil,
        input logic      free_nil
    );
        logic [7:0] code;
        code = ERR_NONE;
        case (f)
            FUNC_NOP:          code = ERR_BAD_FUNC;
            FUNC_GET_CONTENTS: if (addr1_nil || addr2_nil) code = ERR_NIL_ADDR;
            FUNC_SET_CONTENTS: if (addr1_nil) code = ERR_NIL_ADDR;
            FUNC_GET_FREE:     if (free_nil) code = ERR_OUT_OF_MEM;
            default:           code = ERR_BAD_FUNC;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/noun_mem_ram.sv
// rtl/noun_mem_ram.sv - noun store, DATA_W x 2^ADDR_W, two sync read ports and one write port
//
// Ports:
//   clk                      clock
//   i_wr_en/i_wr_addr/i_wr_data  write port, lands on the rising edge
//   i_rd_en                  captures both read ports on the rising edge
//   i_rd_addr1/i_rd_addr2    read addresses
//   o_rd_data1/o_rd_data2    registered read data, held while i_rd_en is low
// Contents are never cleared; there is no reset on the array or its read registers.
module noun_mem_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data1 <= r_mem[i_rd_addr1];
            r_rd_data2 <= r_mem[i_rd_addr2];
        end
    end

    assign o_rd_data1 = r_rd_data1;
    assign o_rd_data2 = r_rd_data2;

endmodule

// File: rtl/noun_mem_responder.sv
// rtl/noun_mem_responder.sv - responder end of the noun-memory request protocol
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   power               requests are accepted only while high
//   mem_execute         request strobe (level-sensitive in IDLE)
//   mem_func            GET_CONTENTS / SET_CONTENTS / GET_FREE, 0 is illegal
//   address1, address2  primary and second read address
//   write_data          SET / GET_FREE payload
//   mem_ready           one-cycle completion pulse, two cycles after acceptance
//   read_data1/2        response words, held until the next completion
//   free_addr           next address GET_FREE will hand out
//   error               sticky first-fault code
module noun_mem_responder
    import noun_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int FREE_START = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              mem_execute,
    input  logic [1:0]        mem_func,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] free_addr,
    output logic [7:0]        error
);

    localparam logic [ADDR_W-1:0] NIL          = '1;
    localparam logic [ADDR_W-1:0] FREE_START_A = ADDR_W'(FREE_START);

    state_e            r_state;
    state_e            w_next_state;
    mem_func_e         r_func;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_free_addr;
    logic [7:0]        r_error;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;

    logic              w_accept;
    logic              w_in_access;
    logic              w_in_respond;
    logic [7:0]        w_fault;
    logic              w_faulted;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_ram_rd1;
    logic [DATA_W-1:0] w_ram_rd2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_in_access  = 1'b0;
        w_in_respond = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (power && mem_execute) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_in_access  = 1'b1;
                w_next_state = ST_RESPOND;
            end
            ST_RESPOND: begin
                w_in_respond = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_func  <= FUNC_NOP;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_func  <= mem_func_e'(mem_func);
            r_addr1 <= address1;
            r_addr2 <= address2;
            r_wdata <= write_data;
        end
    end

    // The fault is a pure function of the latched request and the allocator
    // head, which only moves at the end of RESPOND, so it is stable across
    // both ACCESS and RESPOND of the same request.
    assign w_fault   = classify_fault(r_func, r_addr1 == NIL, r_addr2 == NIL,
                                      r_free_addr == NIL);
    assign w_faulted = (w_fault != ERR_NONE);

    assign w_wr_en   = w_in_access && !w_faulted &&
                       ((r_func == FUNC_SET_CONTENTS) || (r_func == FUNC_GET_FREE));
    assign w_wr_addr = (r_func == FUNC_GET_FREE) ? r_free_addr : r_addr1;
    assign w_rd_en   = w_in_access && (r_func == FUNC_GET_CONTENTS);

    noun_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (r_wdata),
        .i_rd_en    (w_rd_en),
        .i_rd_addr1 (r_addr1),
        .i_rd_addr2 (r_addr2),
        .o_rd_data1 (w_ram_rd1),
        .o_rd_data2 (w_ram_rd2)
    );

    // ---------------- allocator and fault register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_free_addr <= FREE_START_A;
        end else if (w_in_respond && !w_faulted && (r_func == FUNC_GET_FREE)) begin
            r_free_addr <= r_free_addr + 1'b1;
        end
    end

    // First fault wins; the code becomes visible during RESPOND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_error <= ERR_NONE;
        end else if (w_in_access && w_faulted && (r_error == ERR_NONE)) begin
            r_error <= w_fault;
        end
    end

    // ---------------- response data ----------------
    // RAM data only exists during RESPOND, so the response is presented
    // combinationally in that cycle and captured to hold it afterwards.
    always_comb begin
        w_rd1 = r_rd1;
        w_rd2 = r_rd2;
        if (w_in_respond) begin
            if (w_faulted) begin
                w_rd1 = '0;
                w_rd2 = '0;
            end else if (r_func == FUNC_GET_CONTENTS) begin
                w_rd1 = w_ram_rd1;
                w_rd2 = w_ram_rd2;
            end else if (r_func == FUNC_GET_FREE) begin
                w_rd1 = DATA_W'(r_free_addr);
                w_rd2 = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (w_in_respond) begin
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
        end
    end

    assign mem_ready  = w_in_respond;
    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;
    assign free_addr  = r_free_addr;
    assign error      = r_error;

endmodule

// File: tb/tb_noun_mem_responder.sv
// tb/tb_noun_mem_responder.sv - self-checking bench for noun_mem_responder
module tb_noun_mem_responder;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [AW-1:0] NIL = 10'h3FF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          power = 1'b0;
    logic          exec_a = 1'b0;
    logic          exec_b = 1'b0;
    logic [1:0]    mem_func = 2'd0;
    logic [AW-1:0] address1 = '0;
    logic [AW-1:0] address2 = '0;
    logic [DW-1:0] write_data = '0;

    logic          ready_a, ready_b;
    logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [AW-1:0] free_a, free_b;
    logic [7:0]    err_a, err_b;

    always #5 clk = ~clk;

    noun_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .FREE_START(512)) dut (
        .clk(clk), .rst(rst), .power(power), .mem_execute(exec_a),
        .mem_func(mem_func), .address1(address1), .address2(address2),
        .write_data(write_data), .mem_ready(ready_a), .read_data1(rd1_a),
        .read_data2(rd2_a), .free_addr(free_a), .error(err_a)
    );

    noun_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .FREE_START(1022)) dut_hi (
        .clk(clk), .rst(rst), .power(power), .mem_execute(exec_b),
        .mem_func(mem_func), .address1(address1), .address2(address2),
        .write_data(write_data), .mem_ready(ready_b), .read_data1(rd1_b),
        .read_data2(rd2_b), .free_addr(free_b), .error(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    // Response capture from the most recent request.
    logic [63:0] cap_rd1, cap_rd2;
    logic [9:0]  cap_free;
    logic [7:0]  cap_err;

    // One request; checks the mem_ready pulse lands exactly in the second
    // cycle after acceptance and lasts one cycle.
    task automatic run_req(input int sel, input logic [1:0] f, input logic [9:0] a1,
                           input logic [9:0] a2, input logic [63:0] wd);
        @(negedge clk);
        power = 1'b1; mem_func = f; address1 = a1; address2 = a2; write_data = wd;
        if (sel == 0) exec_a = 1'b1; else exec_b = 1'b1;
        @(negedge clk);
        exec_a = 1'b0; exec_b = 1'b0;
        check("ready_low_in_access", 64'(get_ready(sel)), 64'd0);
        @(negedge clk);
        check("ready_in_respond", 64'(get_ready(sel)), 64'd1);
        cap_rd1 = (sel == 0) ? rd1_a : rd1_b;
        cap_rd2 = (sel == 0) ? rd2_a : rd2_b;
        cap_err = (sel == 0) ? err_a : err_b;
        @(negedge clk);
        check("ready_one_cycle", 64'(get_ready(sel)), 64'd0);
        cap_free = (sel == 0) ? free_a : free_b;
    endtask

    // ---------------- reference model of dut (FREE_START=512) ----------------
    logic [63:0] m_mem   [1024];
    bit          m_valid [1024];
    logic [9:0]  m_free;
    logic [7:0]  m_err;
    logic [63:0] m_rd1, m_rd2;
    bit          m_k1, m_k2;

    task automatic model_reset();
        m_free = 10'd512; m_err = 8'h00; m_rd1 = '0; m_rd2 = '0; m_k1 = 1; m_k2 = 1;
    endtask

    task automatic model_req(input logic [1:0] f, input logic [9:0] a1,
                             input logic [9:0] a2, input logic [63:0] wd);
        logic [7:0] code;
        code = 8'h00;
        if (f == 2'd0) code = 8'h01;
        else if (f == 2'd1 && (a1 == NIL || a2 == NIL)) code = 8'h02;
        else if (f == 2'd2 && a1 == NIL) code = 8'h02;
        else if (f == 2'd3 && m_free == NIL) code = 8'h03;
        if (m_err == 8'h00) m_err = code;
        if (code != 8'h00) begin
            m_rd1 = '0; m_rd2 = '0; m_k1 = 1; m_k2 = 1;
        end else if (f == 2'd1) begin
            m_rd1 = m_mem[a1]; m_k1 = m_valid[a1];
            m_rd2 = m_mem[a2]; m_k2 = m_valid[a2];
        end else if (f == 2'd2) begin
            m_mem[a1] = wd; m_valid[a1] = 1;
        end else begin
            m_rd1 = {54'd0, m_free}; m_rd2 = '0; m_k1 = 1; m_k2 = 1;
            m_mem[m_free] = wd; m_valid[m_free] = 1;
            m_free = m_free + 10'd1;
        end
    endtask

    function automatic logic [9:0] pick_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return NIL;
        if (r < 4 && m_free > 10'd512) return 10'($urandom_range(512, int'(m_free) - 1));
        return 10'($urandom_range(0, 15));
    endfunction

    typedef struct {
        logic [1:0]  f;
        logic [9:0]  a1, a2;
        logic [63:0] wd;
        logic [63:0] e_rd1, e_rd2;
        logic [9:0]  e_free;
        logic [7:0]  e_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int pulses;
        logic [9:0] free0;

        vecs[0]  = '{2'd2, 10'd5,   10'd0,   64'hA0000001_00000002, 64'd0, 64'd0, 10'd512, 8'h00};
        vecs[1]  = '{2'd2, 10'd6,   10'd0,   64'h1, 64'd0, 64'd0, 10'd512, 8'h00};
        vecs[2]  = '{2'd1, 10'd5,   10'd6,   64'h0, 64'hA0000001_00000002, 64'h1, 10'd512, 8'h00};
        vecs[3]  = '{2'd2, 10'd7,   10'd0,   64'hDEAD_BEEF, 64'hA0000001_00000002, 64'h1, 10'd512, 8'h00};
        vecs[4]  = '{2'd1, 10'd7,   10'd5,   64'h0, 64'hDEAD_BEEF, 64'hA0000001_00000002, 10'd512, 8'h00};
        vecs[5]  = '{2'd3, 10'd0,   10'd0,   64'h1, 64'd512, 64'd0, 10'd513, 8'h00};
        vecs[6]  = '{2'd3, 10'd0,   10'd0,   64'h2, 64'd513, 64'd0, 10'd514, 8'h00};
        vecs[7]  = '{2'd3, 10'd0,   10'd0,   64'h3, 64'd514, 64'd0, 10'd515, 8'h00};
        vecs[8]  = '{2'd1, 10'd513, 10'd512, 64'h0, 64'h2, 64'h1, 10'd515, 8'h00};
        vecs[9]  = '{2'd0, 10'd7,   10'd7,   64'h0, 64'd0, 64'd0, 10'd515, 8'h01};
        vecs[10] = '{2'd2, NIL,     10'd0,   64'h5, 64'd0, 64'd0, 10'd515, 8'h01};
        vecs[11] = '{2'd1, 10'd7,   10'd7,   64'h0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 10'd515, 8'h01};

        // ---- reset state ----
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("rst_rd1", rd1_a, 64'd0);
        check("rst_rd2", rd2_a, 64'd0);
        check("rst_free", 64'(free_a), 64'd512);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_free_hi", 64'(free_b), 64'd1022);
        rst = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < 12; i++) begin
            run_req(0, vecs[i].f, vecs[i].a1, vecs[i].a2, vecs[i].wd);
            model_req(vecs[i].f, vecs[i].a1, vecs[i].a2, vecs[i].wd);
            check($sformatf("vec%0d_rd1", i), cap_rd1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), cap_rd2, vecs[i].e_rd2);
            check($sformatf("vec%0d_err", i), 64'(cap_err), 64'(vecs[i].e_err));
            check($sformatf("vec%0d_free", i), 64'(cap_free), 64'(vecs[i].e_free));
        end

        // ---- allocator exhaustion on the FREE_START=1022 instance ----
        run_req(1, 2'd3, 10'd0, 10'd0, 64'd77);
        check("oom_first_rd1", cap_rd1, 64'd1022);
        check("oom_first_free", 64'(cap_free), 64'd1023);
        check("oom_first_err", 64'(cap_err), 64'd0);
        run_req(1, 2'd3, 10'd0, 10'd0, 64'd88);
        check("oom_second_rd1", cap_rd1, 64'd0);
        check("oom_second_rd2", cap_rd2, 64'd0);
        check("oom_second_err", 64'(cap_err), 64'h03);
        check("oom_second_free", 64'(cap_free), 64'd1023);
        run_req(1, 2'd1, 10'd1022, 10'd1022, 64'd0);
        check("oom_readback", cap_rd1, 64'd77);
        check("oom_err_sticky", 64'(cap_err), 64'h03);

        // ---- power low: no acceptance ----
        @(negedge clk);
        free0 = free_a;
        power = 1'b0; mem_func = 2'd3; write_data = 64'h99; exec_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_a) pulses++;
        end
        exec_a = 1'b0; power = 1'b1;
        check("power_off_pulses", 64'(pulses), 64'd0);
        check("power_off_free", 64'(free_a), 64'(free0));

        // ---- execute held four cycles re-issues ----
        mem_func = 2'd3; address1 = 10'd0; write_data = 64'h55; exec_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready_a) pulses++;
        end
        exec_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready_a) pulses++;
        end
        model_req(2'd3, 10'd0, 10'd0, 64'h55);
        model_req(2'd3, 10'd0, 10'd0, 64'h55);
        check("held_exec_pulses", 64'(pulses), 64'd2);
        check("held_exec_free", 64'(free_a), 64'(m_free));

        // ---- reset during ACCESS of a SET ----
        run_req(0, 2'd2, 10'd9, 10'd0, 64'h1111);
        model_req(2'd2, 10'd9, 10'd0, 64'h1111);
        @(negedge clk);
        mem_func = 2'd2; address1 = 10'd9; write_data = 64'h2222; exec_a = 1'b1;
        @(negedge clk);
        exec_a = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_a), 64'd0);
        check("midrst_free", 64'(free_a), 64'd512);
        check("midrst_err", 64'(err_a), 64'd0);
        check("midrst_rd1", rd1_a, 64'd0);
        check("midrst_err_hi", 64'(err_b), 64'd0);
        check("midrst_free_hi", 64'(free_b), 64'd1022);
        @(negedge clk);
        @(negedge clk);
        check("midrst_no_pulse", 64'(ready_a), 64'd0);
        rst = 1'b1;
        model_reset();
        run_req(0, 2'd1, 10'd9, 10'd9, 64'd0);
        check("midrst_addr9_kept", cap_rd1, 64'h1111);

        // ---- randomized against the model ----
        for (int a = 0; a < 16; a++) begin
            logic [63:0] wd;
            wd = {$urandom, $urandom};
            run_req(0, 2'd2, 10'(a), 10'd0, wd);
            model_req(2'd2, 10'(a), 10'd0, wd);
        end
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  f;
            logic [9:0]  a1, a2;
            logic [63:0] wd;
            f  = (($urandom_range(0, 39) == 0) ? 2'd0 : 2'($urandom_range(1, 3)));
            a1 = pick_addr();
            a2 = pick_addr();
            wd = {$urandom, $urandom};
            run_req(0, f, a1, a2, wd);
            model_req(f, a1, a2, wd);
            if (m_k1) check($sformatf("rnd%0d_rd1", i), cap_rd1, m_rd1);
            if (m_k2) check($sformatf("rnd%0d_rd2", i), cap_rd2, m_rd2);
            check($sformatf("rnd%0d_err", i), 64'(cap_err), 64'(m_err));
            check($sformatf("rnd%0d_free", i), 64'(cap_free), 64'(m_free));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
